// File: rtl/pipe_mem_stage.sv
// MEM stage of the five-stage pipeline: issues loads/stores to a
// variable-latency data memory over a req/ack handshake, stalls upstream
// while an access is outstanding, aborts on timeout, and holds the MEM/WB
// pipeline register feeding write-back.
module pipe_mem_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mwreg,
  input  logic        mm2reg,
  input  logic        mwmem,
  input  logic [4:0]  mrn,
  input  logic [31:0] malu,
  input  logic [31:0] mb,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        mstall,
  output logic        merr,
  output logic        wwreg,
  output logic        wm2reg,
  output logic [4:0]  wrn,
  output logic [31:0] walu,
  output logic [31:0] wmo
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Timeout limit narrowed to the counter width (legal range is 1..255).
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        dm_req_q, dm_req_d;
  logic        dm_we_q, dm_we_d;
  logic        merr_q, merr_d;
  logic        abort_q, abort_d;
  logic [31:0] lbuf_q, lbuf_d;

  logic        wwreg_q, wwreg_d;
  logic        wm2reg_q, wm2reg_d;
  logic [4:0]  wrn_q, wrn_d;
  logic [31:0] walu_q, walu_d;
  logic [31:0] wmo_q, wmo_d;

  logic        mem_op;
  logic        is_load;
  logic        stall;

  // A store wins when both load and store flags are set.
  assign mem_op  = mm2reg | mwmem;
  assign is_load = mm2reg & ~mwmem;

  // Address and data come straight from EX/MEM, which is frozen during the access.
  assign dm_addr  = {malu[31:2], 2'b00};
  assign dm_wdata = mb;

  // Stall depends only on state and decode so no ack-to-stall path exists.
  always_comb begin
    stall = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_op) begin
          stall = 1'b1;
        end else begin
          stall = 1'b0;
        end
      end
      ST_REQ:  stall = 1'b1;
      ST_DONE: stall = 1'b0;
      default: stall = 1'b0;
    endcase
  end

  // Handshake FSM: issue request, wait for ack or timeout, then retire.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dm_req_d = dm_req_q;
    dm_we_d  = dm_we_q;
    merr_d   = merr_q;
    abort_d  = abort_q;
    lbuf_d   = lbuf_q;
    case (state_q)
      ST_IDLE: begin
        if (mem_op) begin
          state_d  = ST_REQ;
          dm_req_d = 1'b1;
          dm_we_d  = mwmem;
          cnt_d    = 8'd0;
          abort_d  = 1'b0;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (dm_ack) begin
          lbuf_d   = dm_rdata;
          dm_req_d = 1'b0;
          state_d  = ST_DONE;
        end else if ((cnt_q + 8'd1) == TO_LIMIT) begin
          cnt_d    = cnt_q + 8'd1;
          dm_req_d = 1'b0;
          merr_d   = 1'b1;
          abort_d  = 1'b1;
          state_d  = ST_DONE;
        end else begin
          cnt_d    = cnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        dm_req_d = 1'b0;
      end
    endcase
  end

  // MEM/WB next value: bubble while stalled, otherwise the instruction in MEM.
  always_comb begin
    wwreg_d  = 1'b0;
    wm2reg_d = 1'b0;
    wrn_d    = 5'd0;
    walu_d   = 32'd0;
    wmo_d    = 32'd0;
    if (!stall) begin
      if ((state_q == ST_DONE) && abort_q) begin
        // Aborted access retires as a full bubble.
        wwreg_d  = 1'b0;
        wm2reg_d = 1'b0;
        wrn_d    = 5'd0;
        walu_d   = 32'd0;
        wmo_d    = 32'd0;
      end else begin
        wwreg_d  = mwreg;
        wm2reg_d = is_load;
        wrn_d    = mrn;
        walu_d   = malu;
        if ((state_q == ST_DONE) && is_load) begin
          wmo_d = lbuf_q;
        end else begin
          wmo_d = 32'd0;
        end
      end
    end else begin
      wwreg_d = 1'b0;
    end
  end

  // State and pipeline registers with synchronous reset taking priority.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      dm_req_q <= 1'b0;
      dm_we_q  <= 1'b0;
      merr_q   <= 1'b0;
      abort_q  <= 1'b0;
      lbuf_q   <= 32'd0;
      wwreg_q  <= 1'b0;
      wm2reg_q <= 1'b0;
      wrn_q    <= 5'd0;
      walu_q   <= 32'd0;
      wmo_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dm_req_q <= dm_req_d;
      dm_we_q  <= dm_we_d;
      merr_q   <= merr_d;
      abort_q  <= abort_d;
      lbuf_q   <= lbuf_d;
      wwreg_q  <= wwreg_d;
      wm2reg_q <= wm2reg_d;
      wrn_q    <= wrn_d;
      walu_q   <= walu_d;
      wmo_q    <= wmo_d;
    end
  end

  assign mstall = stall;
  assign dm_req = dm_req_q;
  assign dm_we  = dm_we_q;
  assign merr   = merr_q;
  assign wwreg  = wwreg_q;
  assign wm2reg = wm2reg_q;
  assign wrn    = wrn_q;
  assign walu   = walu_q;
  assign wmo    = wmo_q;

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Directed bench for pipe_mem_stage: ALU pass-through, load with wait
// states, store, timeout abort, reset mid-access and back-to-back accesses.
module tb_pipe_mem_stage;

  logic        clock;
  logic        reset;
  logic        mwreg, mm2reg, mwmem;
  logic [4:0]  mrn;
  logic [31:0] malu, mb;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        mstall, merr;
  logic        wwreg, wm2reg;
  logic [4:0]  wrn;
  logic [31:0] walu, wmo;

  int passed;
  int total;
  int failed;

  pipe_mem_stage #(.TIMEOUT(4)) dut (
    .clock(clock), .reset(reset),
    .mwreg(mwreg), .mm2reg(mm2reg), .mwmem(mwmem),
    .mrn(mrn), .malu(malu), .mb(mb),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mstall(mstall), .merr(merr),
    .wwreg(wwreg), .wm2reg(wm2reg), .wrn(wrn), .walu(walu), .wmo(wmo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and let registered outputs settle.
  task automatic go();
    @(posedge clock);
    #1;
  endtask

  task automatic set_op(input logic wr, input logic ld, input logic st,
                        input logic [4:0] rn, input logic [31:0] alu, input logic [31:0] b);
    mwreg = wr; mm2reg = ld; mwmem = st; mrn = rn; malu = alu; mb = b;
    #1;
  endtask

  initial begin
    passed = 0; total = 0; failed = 0;
    reset = 1'b1; dm_ack = 1'b0; dm_rdata = 32'd0;
    mwreg = 1'b0; mm2reg = 1'b0; mwmem = 1'b0; mrn = 5'd0; malu = 32'd0; mb = 32'd0;
    go(); go();
    reset = 1'b0;
    #1;
    chk("rst_dm_req", 32'(dm_req), 32'd0);
    chk("rst_dm_we",  32'(dm_we),  32'd0);
    chk("rst_merr",   32'(merr),   32'd0);
    chk("rst_mstall", 32'(mstall), 32'd0);
    chk("rst_wwreg",  32'(wwreg),  32'd0);
    chk("rst_wrn",    32'(wrn),    32'd0);
    chk("rst_walu",   walu,        32'd0);
    chk("rst_wmo",    wmo,         32'd0);

    // ALU op passes through in one cycle
    set_op(1'b1, 1'b0, 1'b0, 5'd5, 32'h0000_1234, 32'd0);
    chk("alu_mstall", 32'(mstall), 32'd0);
    go();
    chk("alu_wwreg",  32'(wwreg),  32'd1);
    chk("alu_wm2reg", 32'(wm2reg), 32'd0);
    chk("alu_wrn",    32'(wrn),    32'd5);
    chk("alu_walu",   walu,        32'h0000_1234);
    chk("alu_wmo",    wmo,         32'd0);

    // Load at 0x103, ack in third REQ cycle
    set_op(1'b1, 1'b1, 1'b0, 5'd7, 32'h0000_0103, 32'd0);
    chk("ld_idle_mstall", 32'(mstall), 32'd1);
    chk("ld_addr",        dm_addr,     32'h0000_0100);
    go();
    chk("ld_req1",        32'(dm_req), 32'd1);
    chk("ld_we",          32'(dm_we),  32'd0);
    chk("ld_req1_mstall", 32'(mstall), 32'd1);
    chk("ld_bubble_wwreg", 32'(wwreg), 32'd0);
    chk("ld_bubble_walu", walu,        32'd0);
    go();
    chk("ld_req2",        32'(dm_req), 32'd1);
    chk("ld_req2_mstall", 32'(mstall), 32'd1);
    go();
    dm_ack = 1'b1; dm_rdata = 32'hCAFE_F00D;
    #1;
    chk("ld_req3_mstall", 32'(mstall), 32'd1);
    go();
    dm_ack = 1'b0; dm_rdata = 32'd0;
    #1;
    chk("ld_done_req",    32'(dm_req), 32'd0);
    chk("ld_done_mstall", 32'(mstall), 32'd0);
    chk("ld_done_wwreg",  32'(wwreg),  32'd0);
    go();
    chk("ld_wwreg",  32'(wwreg),  32'd1);
    chk("ld_wm2reg", 32'(wm2reg), 32'd1);
    chk("ld_wrn",    32'(wrn),    32'd7);
    chk("ld_walu",   walu,        32'h0000_0103);
    chk("ld_wmo",    wmo,         32'hCAFE_F00D);

    // Store follows immediately, ack on first REQ cycle
    set_op(1'b0, 1'b0, 1'b1, 5'd0, 32'h0000_0020, 32'hA5A5_A5A5);
    chk("b2b_gap_req",    32'(dm_req), 32'd0);
    chk("st_idle_mstall", 32'(mstall), 32'd1);
    chk("st_wdata",       dm_wdata,    32'hA5A5_A5A5);
    chk("st_addr",        dm_addr,     32'h0000_0020);
    go();
    dm_ack = 1'b1;
    #1;
    chk("st_req1",        32'(dm_req), 32'd1);
    chk("st_we",          32'(dm_we),  32'd1);
    chk("st_req1_mstall", 32'(mstall), 32'd1);
    go();
    dm_ack = 1'b0;
    #1;
    chk("st_done_req",    32'(dm_req), 32'd0);
    chk("st_done_mstall", 32'(mstall), 32'd0);
    go();
    chk("st_wwreg",  32'(wwreg),  32'd0);
    chk("st_wm2reg", 32'(wm2reg), 32'd0);
    chk("st_walu",   walu,        32'h0000_0020);
    chk("st_wmo",    wmo,         32'd0);

    // Timeout: no ack, TIMEOUT = 4
    set_op(1'b1, 1'b1, 1'b0, 5'd3, 32'h0000_0040, 32'd0);
    chk("to_idle_mstall", 32'(mstall), 32'd1);
    go(); chk("to_req1", 32'(dm_req), 32'd1);
    go(); chk("to_req2", 32'(dm_req), 32'd1);
    go(); chk("to_req3", 32'(dm_req), 32'd1);
    go(); chk("to_req4", 32'(dm_req), 32'd1);
    chk("to_merr_pre", 32'(merr), 32'd0);
    go();
    chk("to_done_req",    32'(dm_req), 32'd0);
    chk("to_merr",        32'(merr),   32'd1);
    chk("to_done_mstall", 32'(mstall), 32'd0);
    go();
    chk("to_wwreg",  32'(wwreg),  32'd0);
    chk("to_wm2reg", 32'(wm2reg), 32'd0);
    chk("to_wrn",    32'(wrn),    32'd0);
    chk("to_walu",   walu,        32'd0);
    chk("to_wmo",    wmo,         32'd0);
    set_op(1'b1, 1'b0, 1'b0, 5'd9, 32'h0000_0055, 32'd0);
    chk("to_alu_mstall", 32'(mstall), 32'd0);
    go();
    chk("to_alu_wwreg",  32'(wwreg), 32'd1);
    chk("to_alu_wrn",    32'(wrn),   32'd9);
    chk("to_merr_stick", 32'(merr),  32'd1);

    // Reset in the second REQ cycle of a load, spurious ack afterwards
    set_op(1'b1, 1'b1, 1'b0, 5'd4, 32'h0000_0080, 32'd0);
    go();
    chk("rs_req1", 32'(dm_req), 32'd1);
    go();
    reset = 1'b1;
    go();
    reset = 1'b0;
    dm_ack = 1'b1; dm_rdata = 32'hDEAD_BEEF;
    set_op(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    chk("rs_req",    32'(dm_req), 32'd0);
    chk("rs_merr",   32'(merr),   32'd0);
    chk("rs_wwreg",  32'(wwreg),  32'd0);
    chk("rs_walu",   walu,        32'd0);
    chk("rs_mstall", 32'(mstall), 32'd0);
    go();
    dm_ack = 1'b0; dm_rdata = 32'd0;
    set_op(1'b1, 1'b0, 1'b0, 5'd2, 32'h0000_0077, 32'd0);
    chk("rs_ack_ignored_req", 32'(dm_req), 32'd0);
    chk("rs_idle_mstall",     32'(mstall), 32'd0);
    go();
    chk("rs_alu_wwreg", 32'(wwreg), 32'd1);
    chk("rs_alu_walu",  walu,       32'h0000_0077);
    chk("rs_alu_wmo",   wmo,        32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_mem_stage.md
# pipe_mem_stage

Memory (MEM) stage of the five-stage pipelined CPU, sitting directly downstream of the EX/MEM pipeline register. It consumes that register's outputs (`mwreg`, `mm2reg`, `mwmem`, `mrn`, `malu`, `mb`) and runs loads and stores against a variable-latency data memory through a req/ack handshake. It stalls the upstream pipeline while an access is outstanding. It also contains the MEM/WB pipeline register that feeds write-back.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum cycles spent in REQ before the access is aborted; range 1..255.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; clears all state on the rising edge while it is high.
- `mwreg` in 1: instruction in MEM writes the register file.
- `mm2reg` in 1: instruction in MEM is a load.
- `mwmem` in 1: instruction in MEM is a store.
- `mrn` in 5: destination register number.
- `malu` in 32: ALU result, used as the effective address.
- `mb` in 32: store data.
- `dm_req` out 1: data-memory request, registered.
- `dm_we` out 1: 1 = write, 0 = read; valid while `dm_req` is high.
- `dm_addr` out 32: word address, `{malu[31:2],2'b00}`.
- `dm_wdata` out 32: write data, equal to `mb`.
- `dm_ack` in 1: memory completion; sampled only while `dm_req` is high.
- `dm_rdata` in 32: read data; valid in the `dm_ack` cycle.
- `mstall` out 1: combinational; holds the PC, IF/ID, ID/EX and EX/MEM registers.
- `merr` out 1: sticky timeout flag.
- `wwreg`, `wm2reg` out 1 each; `wrn` out 5; `walu` out 32; `wmo` out 32: MEM/WB register outputs.

## Operation
- Memory op: `mm2reg | mwmem`. If both are set, the instruction is treated as a store and `wm2reg` is forced to 0.
- FSM states are IDLE, REQ and DONE. The reset state is IDLE.
- **IDLE**
  - Non-memory op: `mstall` = 0 and MEM/WB loads the instruction.
  - Memory op: `mstall` = 1; the FSM moves to REQ and sets `dm_req` = 1, `dm_we` = `mwmem`, and clears the timeout counter.
- **REQ**
  - `mstall` = 1 and `dm_req` is held high. `dm_addr`, `dm_wdata` and `dm_we` stay stable because EX/MEM is stalled.
  - On `dm_ack`: capture `dm_rdata` into the load buffer, drop `dm_req`, and go to DONE.
  - Otherwise the counter increments. When it reaches `TIMEOUT` with no ack: drop `dm_req`, set `merr`, mark the access aborted, and go to DONE.
- **DONE**
  - `mstall` = 0. MEM/WB loads the instruction with `wmo` taken from the load buffer, and the FSM returns to IDLE.
  - Aborted access: `wwreg` = 0, `wm2reg` = 0, `wmo` = 0.
- MEM/WB loading:
  - Any cycle with `mstall` = 1 loads a bubble: `wwreg` = 0, `wm2reg` = 0, `wrn` = 0, `walu` = 0, `wmo` = 0.
  - Non-stall cycles load `wwreg` = `mwreg`, `wm2reg` = `mm2reg`, `wrn` = `mrn`, `walu` = `malu`.
  - For non-loads, `wmo` = 0.
- `dm_ack` in IDLE or DONE is ignored and does not change state.
- `merr` is cleared only by `reset`.

## Timing
- Reset values: `dm_req` = 0, `dm_we` = 0, `merr` = 0, all MEM/WB outputs = 0, FSM in IDLE, counter = 0.
- `reset` takes priority over `dm_ack` and over timeout. Reset during REQ drops `dm_req` at that edge with no retry.
- `mstall` is a combinational function of the state and the memory-op decode only. It must not depend on `dm_ack`, so there is no ack→stall path.
- Non-memory op: 1 cycle in MEM, results visible on the W outputs after the next edge.
- Memory op with ack on the first REQ cycle: 3 cycles in MEM (IDLE, REQ, DONE) and 2 stall cycles. Each extra ack-wait cycle adds one cycle of `mstall`.
- Timeout: the abort happens at the end of the `TIMEOUT`-th REQ cycle, so `dm_req` is high for exactly `TIMEOUT` cycles.
- Back-to-back memory ops: after DONE the next instruction arrives in IDLE and issues its request one cycle later. `dm_req` is therefore never high in two adjacent accesses without at least two low cycles between them.

## Test plan
- ALU op (`mwreg` = 1, `mrn` = 5, `malu` = 0x1234) → no stall; next cycle `wwreg` = 1, `wrn` = 5, `walu` = 0x1234, `wmo` = 0.
- Load with `malu` = 0x103 and ack 3 cycles after req with `dm_rdata` = 0xCAFEF00D → `dm_addr` = 0x100, `dm_we` = 0, `mstall` high for 4 cycles, W bubbles during the stall, then `wm2reg` = 1, `wmo` = 0xCAFEF00D.
- Store with `malu` = 0x20, `mb` = 0xA5A5A5A5, ack on the first REQ cycle → `dm_we` = 1, `dm_wdata` = 0xA5A5A5A5, exactly 2 stall cycles, `wwreg` = 0.
- `TIMEOUT` = 4 with no ack → `dm_req` high for 4 cycles, then `merr` = 1 (sticky), W outputs all 0; the following ALU op proceeds unstalled.
- Assert `reset` in the second REQ cycle of a load, with a spurious ack one cycle later → `dm_req` = 0 and all outputs 0 after the edge; the spurious ack is ignored and the FSM stays in IDLE.
- Load immediately followed by a store → two separate handshakes, correct `dm_we` for each, and no overlapping `dm_req`.
